// File: rtl/fp32_pkg.sv
// Shared constants, FSM state type and field helpers for the fp32 blocks.
// Imported by the classifier and the fp32-to-int32 converter.
package fp32_pkg;

   localparam logic [7:0]  FP_BIAS      = 8'd127;
   localparam logic [7:0]  FP_INT_BASE  = 8'd150;
   localparam logic [7:0]  FP_INT_LIMIT = 8'd158;
   localparam logic [7:0]  FP_EXP_MAX   = 8'd255;
   localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN    = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      NEG   = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic fp_sign(input logic [31:0] v);
      return v[31];
   endfunction

   function automatic logic [7:0] fp_exp(input logic [31:0] v);
      return v[30:23];
   endfunction

   function automatic logic [22:0] fp_frac(input logic [31:0] v);
      return v[22:0];
   endfunction

   // |E-150| for 127<=E<=157. The result is at most 23, so 5-bit modular
   // arithmetic on the low exponent bits gives the exact distance.
   function automatic logic [4:0] shift_count(input logic [7:0] e, input logic left);
      logic [4:0] cnt;
      if (left) begin
         cnt = e[4:0] - FP_INT_BASE[4:0];
      end else begin
         cnt = FP_INT_BASE[4:0] - e[4:0];
      end
      return cnt;
   endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational unpacker for an fp32 word: sign, exponent, mantissa with
// hidden bit, and the zero/denormal/infinity/NaN class flags.
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0] in_i,
   output logic        sign_o,
   output logic [7:0]  exp_o,
   output logic [23:0] mant_o,
   output logic        is_zero_o,
   output logic        is_inf_o,
   output logic        is_nan_o,
   output logic        is_denorm_o
);

   logic [7:0]  exp_s;
   logic [22:0] frac_s;
   logic        exp_zero_s;
   logic        exp_max_s;
   logic        frac_zero_s;

   assign exp_s       = fp_exp(in_i);
   assign frac_s      = fp_frac(in_i);
   assign exp_zero_s  = (exp_s == 8'd0);
   assign exp_max_s   = (exp_s == FP_EXP_MAX);
   assign frac_zero_s = (frac_s == 23'd0);

   assign sign_o      = fp_sign(in_i);
   assign exp_o       = exp_s;
   assign mant_o      = {~exp_zero_s, frac_s};
   assign is_zero_o   = exp_zero_s & frac_zero_s;
   assign is_denorm_o = exp_zero_s & ~frac_zero_s;
   assign is_inf_o    = exp_max_s & frac_zero_s;
   assign is_nan_o    = exp_max_s & ~frac_zero_s;

endmodule

// File: rtl/fp32_to_int32.sv
// Iterative fp32 -> int32 converter, truncating toward zero, with saturation
// and invalid/inexact flags. One bit of denormalizing shift per clock.
module fp32_to_int32
   import fp32_pkg::*;
#(
   parameter logic [31:0] NAN_RESULT = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_invalid,
   output logic        out_inexact
);

   state_e      state_q, state_d;
   logic [31:0] mag_q, mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        left_q, left_d;
   logic        sticky_q, sticky_d;
   logic        sign_q, sign_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        out_invalid_q, out_invalid_d;
   logic        out_inexact_q, out_inexact_d;

   logic        cls_sign_s;
   logic [7:0]  cls_exp_s;
   logic [23:0] cls_mant_s;
   logic        cls_is_zero_s;
   logic        cls_is_inf_s;
   logic        cls_is_nan_s;
   logic        cls_is_denorm_s;
   logic        in_ready_s;
   logic        in_fire_s;
   logic        exact_min_s;
   logic        go_left_s;

   fp32_classify u_classify (
      .in_i        (in_data),
      .sign_o      (cls_sign_s),
      .exp_o       (cls_exp_s),
      .mant_o      (cls_mant_s),
      .is_zero_o   (cls_is_zero_s),
      .is_inf_o    (cls_is_inf_s),
      .is_nan_o    (cls_is_nan_s),
      .is_denorm_o (cls_is_denorm_s)
   );

   assign in_ready_s  = (state_q == IDLE) & ~rst;
   assign in_fire_s   = in_valid & in_ready_s;
   // -2^31 is the only E=158 value that still fits in an int32.
   assign exact_min_s = cls_sign_s & (cls_exp_s == FP_INT_LIMIT) & (cls_mant_s[22:0] == 23'd0);
   assign go_left_s   = (cls_exp_s >= FP_INT_BASE);

   // Next-state, datapath and result logic for the convert FSM.
   always_comb begin
      state_d       = state_q;
      mag_d         = mag_q;
      cnt_d         = cnt_q;
      left_d        = left_q;
      sticky_d      = sticky_q;
      sign_d        = sign_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_invalid_d = out_invalid_q;
      out_inexact_d = out_inexact_q;

      case (state_q)
         IDLE: begin
            if (in_fire_s) begin
               sign_d        = cls_sign_s;
               out_data_d    = 32'h0000_0000;
               out_invalid_d = 1'b0;
               out_inexact_d = 1'b0;
               if (cls_is_zero_s || cls_is_denorm_s) begin
                  state_d       = DONE;
                  out_valid_d   = 1'b1;
                  out_inexact_d = cls_is_denorm_s;
               end else if (cls_is_nan_s) begin
                  state_d       = DONE;
                  out_valid_d   = 1'b1;
                  out_data_d    = NAN_RESULT;
                  out_invalid_d = 1'b1;
               end else if (exact_min_s) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = INT32_MIN;
               end else if (cls_is_inf_s || (cls_exp_s >= FP_INT_LIMIT)) begin
                  state_d       = DONE;
                  out_valid_d   = 1'b1;
                  out_data_d    = cls_sign_s ? INT32_MIN : INT32_MAX;
                  out_invalid_d = 1'b1;
               end else if (cls_exp_s < FP_BIAS) begin
                  state_d       = DONE;
                  out_valid_d   = 1'b1;
                  out_inexact_d = 1'b1;
               end else begin
                  state_d  = SHIFT;
                  mag_d    = {8'd0, cls_mant_s};
                  left_d   = go_left_s;
                  cnt_d    = shift_count(cls_exp_s, go_left_s);
                  sticky_d = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
               if (left_q) begin
                  mag_d = {mag_q[30:0], 1'b0};
               end else begin
                  mag_d    = {1'b0, mag_q[31:1]};
                  sticky_d = sticky_q | mag_q[0];
               end
            end else begin
               state_d = NEG;
            end
         end
         NEG: begin
            state_d       = DONE;
            out_valid_d   = 1'b1;
            out_data_d    = sign_q ? (32'd0 - mag_q) : mag_q;
            out_invalid_d = 1'b0;
            out_inexact_d = sticky_q;
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mag_q         <= 32'd0;
         cnt_q         <= 5'd0;
         left_q        <= 1'b0;
         sticky_q      <= 1'b0;
         sign_q        <= 1'b0;
         out_data_q    <= 32'd0;
         out_valid_q   <= 1'b0;
         out_invalid_q <= 1'b0;
         out_inexact_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mag_q         <= mag_d;
         cnt_q         <= cnt_d;
         left_q        <= left_d;
         sticky_q      <= sticky_d;
         sign_q        <= sign_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_invalid_q <= out_invalid_d;
         out_inexact_q <= out_inexact_d;
      end
   end

   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_invalid = out_invalid_q;
   assign out_inexact = out_inexact_q;

endmodule
